// File: rtl/tone_arbiter_pkg.sv
// Shared types and constants for the tone arbiter: FSM states, default gap
// length, a few named note frequencies and the prescaler divisor helper.
package tone_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEFAULT_GAP_MS = 20;
    localparam int TICK_W         = 16;

    localparam int G3 = 196;
    localparam int C4 = 262;
    localparam int E4 = 330;
    localparam int G5 = 784;

    // A programmed divisor of 0 would never produce a tick, so it behaves as 1.
    function automatic logic [TICK_W-1:0] effective_ticks(input logic [TICK_W-1:0] t);
        return (t == '0) ? TICK_W'(1) : t;
    endfunction

endpackage

// File: rtl/tone_arbiter_milli.sv
// Millisecond prescaler for the tone arbiter. Counts 0..T-1 with
// T = max(ticks_per_milli, 1) and flags ms_tick while the count sits on T-1.
// 'clear' restarts the count so a freshly granted note gets whole milliseconds.
module milli_ticker
    import tone_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [TICK_W-1:0] ticks_per_milli,
    output logic              ms_tick
);

    logic [TICK_W-1:0] count;
    logic [TICK_W-1:0] last;

    assign last = effective_ticks(ticks_per_milli) - TICK_W'(1);

    // Greater-or-equal also recovers cleanly if the divisor shrinks mid-count.
    assign ms_tick = (count >= last);

    // Free-running cycle counter that wraps once per millisecond.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count >= last) begin
            count <= '0;
        end else begin
            count <= count + TICK_W'(1);
        end
    end

endmodule

// File: rtl/tone_arbiter.sv
// Fixed-priority arbiter sharing one square-wave tone generator between N
// requesters. Each granted request is a note (frequency, duration in ms);
// the note is timed with a millisecond prescaler and followed by a silent gap
// of GAP_MS milliseconds so consecutive notes remain distinct.
//
// Optional build macro TONE_ARBITER_PREEMPT_EN: a higher-priority request
// arriving during PLAY aborts the current note and is granted immediately,
// with no gap. Without the macro notes always run to completion and
// 'aborted' stays 0.
module tone_arbiter
    import tone_arbiter_pkg::*;
#(
    parameter int N      = 4,
    parameter int GAP_MS = DEFAULT_GAP_MS,
    parameter int FREQ_W = 10,
    parameter int DUR_W  = 10
)(
    input  logic                 clk,
    input  logic                rst,
    input  logic [TICK_W-1:0]   ticks_per_milli,
    input  logic [N-1:0]        req,
    input  logic [N*FREQ_W-1:0] req_freq,
    input  logic [N*DUR_W-1:0]  req_dur,
    output logic [N-1:0]        ack,
    output logic [N-1:0]        done,
    output logic [N-1:0]        aborted,
    output logic [FREQ_W-1:0]   freq,
    output logic                busy
);

    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam int GAP_W    = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
    localparam int GAP_LAST = (GAP_MS > 0) ? GAP_MS - 1 : 0;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [DUR_W-1:0]   lat_dur;
    logic [DUR_W-1:0]   ms_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [IDX_W-1:0]   win_idx;
    logic               req_any;
    logic [FREQ_W-1:0]  sel_freq;
    logic [DUR_W-1:0]   sel_dur;
    logic               ms_tick;
    logic               note_end;
    logic               gap_end;
    logic               enter_gap;
    logic               grant_now;
    logic               ticker_clear;

    milli_ticker u_ticker (
        .clk             (clk),
        .rst             (rst),
        .clear           (ticker_clear),
        .ticks_per_milli (ticks_per_milli),
        .ms_tick         (ms_tick)
    );

    // Lowest set request index wins; scanning downwards leaves the smallest one.
    always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    assign req_any  = |req;
    assign sel_freq = req_freq[int'(win_idx)*FREQ_W +: FREQ_W];
    assign sel_dur  = req_dur[int'(win_idx)*DUR_W +: DUR_W];

    // A zero-length note ends on its first PLAY cycle; otherwise the note ends
    // on the tick that would bring the ms counter up to the latched duration,
    // which keeps the tone audible for exactly D*T cycles.
    assign note_end  = (state == PLAY) &&
                       ((lat_dur == '0) || (ms_tick && (ms_cnt == lat_dur - DUR_W'(1))));
    assign gap_end   = (state == GAP) && ms_tick && (gap_cnt == GAP_W'(GAP_LAST));
    assign enter_gap = note_end && (GAP_MS != 0);

`ifdef TONE_ARBITER_PREEMPT_EN
    logic [N-1:0] aborted_q;
    logic         preempt_now;

    // Completion takes precedence over pre-emption on the same edge.
    assign preempt_now = (state == PLAY) && !note_end && req_any && (win_idx < owner);
    assign grant_now   = ((state == IDLE) && req_any) || preempt_now;
    assign aborted     = aborted_q;
`else
    assign grant_now   = (state == IDLE) && req_any;
    assign aborted     = '0;
`endif

    // Restart the prescaler on every grant and at gap entry so both the note
    // and the gap are measured in whole milliseconds from their first cycle.
    assign ticker_clear = grant_now || enter_gap;

    // Arbitration FSM: grants, note timing, gap timing and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= '0;
            lat_dur <= '0;
            ms_cnt  <= '0;
            gap_cnt <= '0;
            freq    <= '0;
            ack     <= '0;
            done    <= '0;
            busy    <= 1'b0;
`ifdef TONE_ARBITER_PREEMPT_EN
            aborted_q <= '0;
`endif
        end else begin
            ack  <= '0;
            done <= '0;
`ifdef TONE_ARBITER_PREEMPT_EN
            aborted_q <= '0;
`endif
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        state        <= PLAY;
                        owner        <= win_idx;
                        lat_dur      <= sel_dur;
                        ms_cnt       <= '0;
                        freq         <= (sel_dur == '0) ? '0 : sel_freq;
                        ack[win_idx] <= 1'b1;
                        busy         <= 1'b1;
                    end else begin
                        freq <= '0;
                        busy <= 1'b0;
                    end
                end

                PLAY: begin
                    if (note_end) begin
                        freq        <= '0;
                        done[owner] <= 1'b1;
                        gap_cnt     <= '0;
                        if (GAP_MS == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
`ifdef TONE_ARBITER_PREEMPT_EN
                    else if (preempt_now) begin
                        aborted_q[owner] <= 1'b1;
                        owner            <= win_idx;
                        lat_dur          <= sel_dur;
                        ms_cnt           <= '0;
                        freq             <= (sel_dur == '0) ? '0 : sel_freq;
                        ack[win_idx]     <= 1'b1;
                    end
`endif
                    else if (ms_tick) begin
                        ms_cnt <= ms_cnt + DUR_W'(1);
                    end
                end

                GAP: begin
                    freq <= '0;
                    if (gap_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (ms_tick) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    freq  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_arbiter.sv
// Self-checking bench for tone_arbiter (ticks_per_milli=4, GAP_MS=2).
// Expected ack/done/aborted events, with their cycle and ack frequency, are
// queued when a request is driven and compared as the DUT pulses them.
// Honours TONE_ARBITER_PREEMPT_EN for the pre-emption scenario.
module tb_tone_arbiter;
    import tone_arbiter_pkg::*;

    localparam int N      = 4;
    localparam int FREQ_W = 10;
    localparam int DUR_W  = 10;
    localparam int GAP_MS = 2;
    localparam int TPM    = 4;
    localparam int GAPC   = GAP_MS * TPM;

    localparam int K_ABORT = 0;
    localparam int K_DONE  = 1;
    localparam int K_ACK   = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [15:0]         ticks_per_milli;
    logic [N-1:0]        req;
    logic [N*FREQ_W-1:0] req_freq;
    logic [N*DUR_W-1:0]  req_dur;
    logic [N-1:0]        ack;
    logic [N-1:0]        done;
    logic [N-1:0]        aborted;
    logic [FREQ_W-1:0]   freq;
    logic                busy;

    typedef struct {
        int kind;
        int idx;
        int cyc;
        int freq;
    } evt_t;

    evt_t exp_q[$];
    int   cyc         = 0;
    int   tone_total  = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    tone_arbiter #(
        .N      (N),
        .GAP_MS (GAP_MS),
        .FREQ_W (FREQ_W),
        .DUR_W  (DUR_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (ticks_per_milli),
        .req             (req),
        .req_freq        (req_freq),
        .req_dur         (req_dur),
        .ack             (ack),
        .done            (done),
        .aborted         (aborted),
        .freq            (freq),
        .busy            (busy)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // Cycle index: number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic pushEvt(input int kind, input int idx, input int c, input int f);
        evt_t e;
        e.kind = kind;
        e.idx  = idx;
        e.cyc  = c;
        e.freq = f;
        exp_q.push_back(e);
    endtask

    function automatic logic evtBit(input int k, input int i);
        if (k == K_ABORT) return aborted[i];
        if (k == K_DONE)  return done[i];
        return ack[i];
    endfunction

    task automatic checkEvent(input int k, input int i);
        evt_t e;
        if (exp_q.size() == 0) begin
            checkOutput("spurious_event", k * 10 + i + 1, 0);
        end else begin
            e = exp_q.pop_front();
            checkOutput("event_kind_idx", k * 10 + i, e.kind * 10 + e.idx);
            checkOutput("event_cycle", cyc, e.cyc);
            if (k == K_ACK) checkOutput("ack_freq", int'(freq), e.freq);
        end
    endtask

    // Scoreboard monitor: pops one expectation per observed pulse, away from the clock edge.
    always @(negedge clk) begin
        if (freq != '0) tone_total++;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                if (evtBit(k, i)) checkEvent(k, i);
            end
        end
    end

    task automatic applyStimulus(input int idx, input int f, input int d);
        req_freq[idx*FREQ_W +: FREQ_W] = FREQ_W'(f);
        req_dur[idx*DUR_W +: DUR_W]    = DUR_W'(d);
        req[idx]                       = 1'b1;
    endtask

    task automatic dropOnAck(input int idx);
        int n;
        n = 0;
        while (!ack[idx] && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ack_seen", int'(ack[idx]), 1);
        req[idx] = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic waitDrainIdle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("queue_drained", exp_q.size(), 0);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("back_to_idle", int'(busy), 0);
        @(negedge clk);
    endtask

    // Hard stop if something hangs outside the bounded waits.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g;
        int t0;

        rst             = 1'b1;
        ticks_per_milli = 16'(TPM);
        req             = '0;
        req_freq        = '0;
        req_dur         = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_freq", int'(freq), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_ack", int'(ack), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_aborted", int'(aborted), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single note on requester 2");
        t0 = tone_total;
        g  = cyc + 1;
        applyStimulus(2, E4, 3);
        pushEvt(K_ACK, 2, g, E4);
        pushEvt(K_DONE, 2, g + 3 * TPM, 0);
        dropOnAck(2);
        waitUntil(g + 3 * TPM + GAPC - 1);
        checkOutput("gap_busy_high", int'(busy), 1);
        @(negedge clk);
        checkOutput("gap_busy_low", int'(busy), 0);
        checkOutput("single_tone_cycles", tone_total - t0, 3 * TPM);
        waitDrainIdle();

        $display("[TB] simultaneous requests 1 and 3");
        t0 = tone_total;
        g  = cyc + 1;
        applyStimulus(1, C4, 2);
        applyStimulus(3, G3, 1);
        pushEvt(K_ACK, 1, g, C4);
        pushEvt(K_DONE, 1, g + 2 * TPM, 0);
        pushEvt(K_ACK, 3, g + 2 * TPM + GAPC + 1, G3);
        pushEvt(K_DONE, 3, g + 2 * TPM + GAPC + 1 + TPM, 0);
        dropOnAck(1);
        dropOnAck(3);
        waitDrainIdle();
        checkOutput("simul_tone_cycles", tone_total - t0, 3 * TPM);

        $display("[TB] zero-length note");
        t0 = tone_total;
        g  = cyc + 1;
        applyStimulus(0, G5, 0);
        pushEvt(K_ACK, 0, g, 0);
        pushEvt(K_DONE, 0, g + 1, 0);
        dropOnAck(0);
        waitDrainIdle();
        checkOutput("zero_len_tone_cycles", tone_total - t0, 0);

        $display("[TB] timed rest");
        t0 = tone_total;
        g  = cyc + 1;
        applyStimulus(1, 0, 2);
        pushEvt(K_ACK, 1, g, 0);
        pushEvt(K_DONE, 1, g + 2 * TPM, 0);
        dropOnAck(1);
        waitDrainIdle();
        checkOutput("rest_tone_cycles", tone_total - t0, 0);

        $display("[TB] ticks_per_milli of zero");
        ticks_per_milli = 16'd0;
        @(negedge clk);
        t0 = tone_total;
        g  = cyc + 1;
        applyStimulus(2, G3, 5);
        pushEvt(K_ACK, 2, g, G3);
        pushEvt(K_DONE, 2, g + 5, 0);
        dropOnAck(2);
        waitDrainIdle();
        checkOutput("tpm0_tone_cycles", tone_total - t0, 5);
        ticks_per_milli = 16'(TPM);
        @(negedge clk);

        $display("[TB] reset in the middle of a note");
        g = cyc + 1;
        applyStimulus(3, E4, 10);
        pushEvt(K_ACK, 3, g, E4);
        dropOnAck(3);
        waitUntil(g + 3);
        checkOutput("pre_reset_freq", int'(freq), E4);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_freq", int'(freq), 0);
        checkOutput("mid_reset_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("mid_reset_queue", exp_q.size(), 0);

        $display("[TB] higher-priority request during a note");
        t0 = tone_total;
        g  = cyc + 1;
        applyStimulus(3, C4, 4);
        pushEvt(K_ACK, 3, g, C4);
        dropOnAck(3);
        waitUntil(g + 4);
        applyStimulus(0, G5, 2);
`ifdef TONE_ARBITER_PREEMPT_EN
        pushEvt(K_ABORT, 3, g + 5, 0);
        pushEvt(K_ACK, 0, g + 5, G5);
        pushEvt(K_DONE, 0, g + 5 + 2 * TPM, 0);
        dropOnAck(0);
        waitDrainIdle();
        checkOutput("preempt_tone_cycles", tone_total - t0, 5 + 2 * TPM);
`else
        pushEvt(K_DONE, 3, g + 4 * TPM, 0);
        pushEvt(K_ACK, 0, g + 4 * TPM + GAPC + 1, G5);
        pushEvt(K_DONE, 0, g + 4 * TPM + GAPC + 1 + 2 * TPM, 0);
        dropOnAck(0);
        waitDrainIdle();
        checkOutput("no_preempt_tone_cycles", tone_total - t0, 6 * TPM);
`endif

        $display("[TB] held request repeats");
        t0 = tone_total;
        g  = cyc + 1;
        applyStimulus(1, E4, 2);
        for (int r = 0; r < 3; r++) begin
            pushEvt(K_ACK, 1, g + r * (2 * TPM + GAPC + 1), E4);
            pushEvt(K_DONE, 1, g + r * (2 * TPM + GAPC + 1) + 2 * TPM, 0);
        end
        waitUntil(g + 2 * (2 * TPM + GAPC + 1));
        req[1] = 1'b0;
        waitDrainIdle();
        checkOutput("held_tone_cycles", tone_total - t0, 3 * 2 * TPM);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
